mem_access_unit: RTL and testbench

- Initiator-side load/store engine that drives the word-addressed data memory (memRead/memWrite/address/writeData/readData) on behalf of the pipeline's MEM stage.
- Accepts one load/store command at a time and performs the required word accesses.
- Supports word, halfword and byte loads (signed and unsigned) and word, halfword and byte stores; sub-word stores are done as read-modify-write.
- Also checks address range and alignment.

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store engine for the word-addressed data memory: byte/half/word loads with
// sign or zero extension, word stores, and sub-word stores done as read-modify-write.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR, S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        accept_err;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [2:0] o, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        r;
    b_s = word[{lane, 3'b000} +: 8];
    h_s = word[{lane[1], 4'b0000} +: 16];
    case (o)
      OP_LB:   r = 32'(b_s);
      OP_LH:   r = 32'(h_s);
      OP_LBU:  r = {24'h0, b_s};
      OP_LHU:  r = {16'h0, h_s};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [2:0] o, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [15:0] d);
    logic [31:0] r;
    r = old;
    if (o == OP_SB) r[{lane, 3'b000} +: 8] = d[7:0];
    else            r[{lane[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  always_comb begin
    accept_err = 1'b0;
    if (addr < BASE_ADDR || {1'b0, addr} >= END_ADDR) accept_err = 1'b1;
    case (op)
      OP_LW, OP_SW:         if (addr[1:0] != 2'b00) accept_err = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (addr[0]) accept_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= 3'b000;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            lane_q   <= addr[1:0];
            wdata_q  <= wdata[15:0];
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            if (accept_err) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end else if (op == OP_SW) begin
              state     <= S_WRITE;
              mem_write <= 1'b1;
              mem_wdata <= wdata;
            end else if (op == OP_SB || op == OP_SH) begin
              state    <= S_RMW_RD;
              mem_read <= 1'b1;
            end else begin
              state    <= S_LOAD;
              mem_read <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          mem_read <= 1'b0;
          rdata    <= load_extract(op_q, lane_q, mem_rdata);
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_WRITE: begin
          mem_write <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_RMW_RD: begin
          // The merged word is formed here so the write cycle only has to drive it.
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_wdata <= store_merge(op_q, lane_q, mem_rdata, wdata_q);
          state     <= S_RMW_WR;
        end
        S_RMW_WR: begin
          mem_write <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random load/store commands against a
// word-array data memory and a byte-lane arithmetic reference model.
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam int          NW   = 4096;

  logic        clk, rst, start;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];
  logic [31:0] ref_rdata;
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_val;
  int          errors = 0;
  int          checks = 0;
  int          both_cnt = 0;

  wire [31:0] mem_off = mem_addr - BASE;
  wire        mem_ok  = (mem_addr >= BASE) && (mem_off < 32'(4 * NW));
  assign mem_rdata = mem_ok ? mem[mem_off[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write && mem_ok) mem[mem_off[13:2]] <= mem_wdata;
  end

  always @(negedge clk) if (mem_read && mem_write) both_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = 12'(idx); pl_val = v;
    ref_mem[idx] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Reference: expected outcome of one command, straight from the byte-lane rules.
  task automatic model_cmd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                           output logic e_err, output int e_cyc, output logic [31:0] e_wword,
                           output logic [7:0] e_rv, output logic [7:0] e_wv);
    longint la, lo;
    int k, b, h, idx;
    logic [31:0] word, mask, v;
    la = longint'(a); lo = longint'(BASE);
    k = int'(a % 4);
    e_err = (la < lo) || (la >= lo + 4 * NW);
    if ((o == 3'b010 || o == 3'b011) && k != 0) e_err = 1'b1;
    if ((o == 3'b001 || o == 3'b101 || o == 3'b111) && (k % 2) != 0) e_err = 1'b1;
    e_wword = 32'h0; e_rv = 8'h0; e_wv = 8'h0;
    if (e_err) begin
      e_cyc = 1; ref_rdata = 32'h0;
      return;
    end
    idx  = int'((la - lo) / 4);
    word = ref_mem[idx];
    b = int'((word >> (8 * k)) % 256);
    h = int'((word >> (16 * (k / 2))) % 65536);
    case (o)
      3'b000: begin v = 32'((b >= 128) ? b - 256 : b);     ref_rdata = v; end
      3'b001: begin v = 32'((h >= 32768) ? h - 65536 : h); ref_rdata = v; end
      3'b100: ref_rdata = 32'(b);
      3'b101: ref_rdata = 32'(h);
      3'b010: ref_rdata = word;
      default: ;
    endcase
    if (o == 3'b011) begin
      e_cyc = 2; e_wv = 8'b0000_0010; e_wword = d; ref_mem[idx] = d;
    end else if (o == 3'b110 || o == 3'b111) begin
      mask = (o == 3'b110) ? (32'hFF << (8 * k)) : (32'hFFFF << (16 * (k / 2)));
      e_wword = (word & ~mask) | ((d << (8 * k)) & mask);
      ref_mem[idx] = e_wword;
      e_cyc = 3; e_rv = 8'b0000_0010; e_wv = 8'b0000_0100;
    end else begin
      e_cyc = 2; e_rv = 8'b0000_0010;
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_cmd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
    logic e_err, bsy_ok;
    int e_cyc, dc;
    logic [31:0] e_wword, seen_addr, seen_wd;
    logic [7:0] e_rv, e_wv, rv, wv;
    longint off;
    model_cmd(o, a, d, e_err, e_cyc, e_wword, e_rv, e_wv);
    start = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom;
    rv = 0; wv = 0; dc = 0; seen_addr = 0; seen_wd = 0; bsy_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) rv[c] = 1'b1;
      if (mem_write) begin wv[c] = 1'b1; seen_wd = mem_wdata; end
      if (mem_read || mem_write) seen_addr = mem_addr;
      if (!busy) bsy_ok = 1'b0;
      if (done) begin dc = c; break; end
    end
    check({tag, ".done_cycle"}, 32'(dc), 32'(e_cyc));
    check({tag, ".err"}, 32'(err), 32'(e_err));
    check({tag, ".rdata"}, rdata, ref_rdata);
    check({tag, ".read_cycles"}, 32'(rv), 32'(e_rv));
    check({tag, ".write_cycles"}, 32'(wv), 32'(e_wv));
    check({tag, ".busy"}, 32'(bsy_ok), 32'd1);
    if (e_rv != 0 || e_wv != 0) check({tag, ".mem_addr"}, seen_addr, {a[31:2], 2'b00});
    if (e_wv != 0) check({tag, ".mem_wdata"}, seen_wd, e_wword);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, {31'h0, done}, 32'h0);
    off = longint'(a) - longint'(BASE);
    if (off >= 0 && off < 4 * NW)
      check({tag, ".mem_word"}, mem[int'(off / 4)], ref_mem[int'(off / 4)]);
  endtask

  initial begin : stim
    logic e_err;
    int e_cyc, dc;
    logic [31:0] e_ww, a;
    logic [7:0] e_rv, e_wv, rv, wv, dv, bv;
    logic [4:0] ctl;
    rst = 1'b1; start = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0; pl_en = 1'b0;
    pl_idx = 12'h0; pl_val = 32'h0; ref_rdata = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(0, 32'hDEADBEEF);
    preload(1, 32'h80F17F02);
    preload(2, 32'h11223344);
    @(negedge clk);
    check("reset.ctl", 32'({busy, done, err, mem_read, mem_write}), 32'h0);
    check("reset.rdata", rdata, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(3'b010, BASE, 32'h0, "lw_base");
    check("lw_base.value", rdata, 32'hDEADBEEF);
    run_cmd(3'b000, BASE + 7, 32'h0, "lb_neg");
    check("lb_neg.value", rdata, 32'hFFFFFF80);
    run_cmd(3'b100, BASE + 7, 32'h0, "lbu");
    check("lbu.value", rdata, 32'h00000080);
    run_cmd(3'b001, BASE + 6, 32'h0, "lh_neg");
    check("lh_neg.value", rdata, 32'hFFFF80F1);
    run_cmd(3'b101, BASE + 4, 32'h0, "lhu");
    check("lhu.value", rdata, 32'h00007F02);
    run_cmd(3'b110, BASE + 9, 32'h000000AA, "sb");
    check("sb.word", mem[2], 32'h1122AA44);
    check("sb.rdata_kept", rdata, 32'h00007F02);
    run_cmd(3'b111, BASE + 10, 32'h00005566, "sh");
    check("sh.word", mem[2], 32'h5566AA44);
    run_cmd(3'b011, BASE + 12, 32'hCAFEF00D, "sw");
    run_cmd(3'b011, BASE + 16380, 32'h0BADC0DE, "sw_last");
    run_cmd(3'b010, BASE + 16380, 32'h0, "lw_last");
    run_cmd(3'b010, BASE + 2, 32'h0, "err_lw_mis");
    run_cmd(3'b111, BASE + 1, 32'h1234, "err_sh_mis");
    run_cmd(3'b010, 32'h1000FFFC, 32'h0, "err_lw_low");
    run_cmd(3'b011, 32'h10014000, 32'h1, "err_sw_high");
    run_cmd(3'b101, BASE + 4, 32'h0, "lhu_after_err");

    // start held high across an SB: the second copy is accepted only after done
    model_cmd(3'b110, BASE + 8, 32'h77, e_err, e_cyc, e_ww, e_rv, e_wv);
    model_cmd(3'b110, BASE + 8, 32'h77, e_err, e_cyc, e_ww, e_rv, e_wv);
    start = 1'b1; op = 3'b110; addr = BASE + 8; wdata = 32'h77;
    @(posedge clk);
    rv = 0; wv = 0; dv = 0; bv = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rv[c] = mem_read; wv[c] = mem_write; dv[c] = done; bv[c] = busy;
    end
    check("held.read_cycles", 32'(rv), 32'b0010_0010);
    check("held.write_cycles", 32'(wv), 32'b0000_0100);
    check("held.done_cycles", 32'(dv), 32'b0000_1000);
    check("held.busy_cycles", 32'(bv), 32'b0010_1110);
    @(posedge clk); #1;
    start = 1'b0;
    dc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin dc = c; break; end
    end
    check("held.second_done", 32'(dc), 32'd2);
    @(posedge clk); #1;
    check("held.word", mem[2], ref_mem[2]);

    // reset taking effect where the SB write cycle would have been
    ref_rdata = 32'h0;
    a = mem[4];
    start = 1'b1; op = 3'b110; addr = BASE + 16; wdata = 32'h99;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort.rmw_read", {31'h0, mem_read}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    ctl = 5'h0;
    @(negedge clk);
    check("abort.rdata", rdata, 32'h0);
    check("abort.mem_addr", mem_addr, 32'h0);
    check("abort.mem_wdata", mem_wdata, 32'h0);
    for (int c = 0; c < 5; c++) begin
      ctl |= {busy, done, err, mem_read, mem_write};
      @(negedge clk);
    end
    check("abort.ctl_quiet", 32'(ctl), 32'h0);
    check("abort.word", mem[4], a);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (sel == 1) a = BASE + 32'(4 * NW) + 32'($urandom_range(0, 15));
      else               a = BASE + 32'($urandom_range(0, 255));
      run_cmd(3'($urandom), a, $urandom, $sformatf("rand%0d", i));
    end

    check("never_read_and_write", 32'(both_cnt), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
